// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display writer.
// Segment codes are active-high, bit0=a .. bit6=g.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Entry n is the active-high pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK_HI = 7'h00;
    localparam logic [6:0] SEG_BLANK_LO = 7'h7F;

endpackage

// File: rtl/seg7_display_writer_if.sv
// Avalon-MM write-only bus between the display writer and the display PIOs.
interface seg7_display_writer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_writedata,
        output avm_waitrequest
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment encoder with selectable polarity and blanking.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    input  logic       active_low_i,
    output logic [6:0] seg_o
);

    always_comb begin
        if (blank_i)
            seg_o = active_low_i ? SEG_BLANK_LO : SEG_BLANK_HI;
        else
            seg_o = active_low_i ? ~SEG_HEX[nib_i] : SEG_HEX[nib_i];
    end

endmodule

// File: rtl/seg7_display_writer.sv
// Avalon-MM master that latches a hex value and writes one encoded digit
// per display PIO, back to back, then pulses done.
module seg7_display_writer
    import seg7_pkg::*;
#(
    parameter int                NUM_DIGITS     = 4,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                STRIDE         = 16,
    parameter bit                SEG_ACTIVE_LOW = 1'b1,
    parameter bit                BLANK_LZ       = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic                    busy,
    output logic                    done,
    seg7_display_writer_if.master   avm
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]      val_q, val_d;
    logic                            upper_nz;
    logic                            blank;
    logic [6:0]                      seg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    val_d   = value;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!avm.avm_waitrequest) begin
                    if (idx_q == LAST_IDX) state_d = DONE;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A digit above 0 is a leading zero when it and every higher nibble are zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (j >= int'(idx_q) && val_q[j] != 4'h0) upper_nz = 1'b1;
    end

    assign blank = BLANK_LZ && (idx_q != '0) && !upper_nz;

    hex_to_seg7 u_enc (
        .nib_i        (val_q[idx_q]),
        .blank_i      (blank),
        .active_low_i (SEG_ACTIVE_LOW),
        .seg_o        (seg)
    );

    // Bus outputs decode straight from state so an async reset drops the write at once.
    assign avm.avm_write     = (state_q == WRITE);
    assign avm.avm_address   = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(STRIDE);
    assign avm.avm_writedata = (state_q == WRITE) ? {25'b0, seg} : 32'b0;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);

endmodule

// File: tb/tb_seg7_display_writer.sv
// Scoreboard bench: three configurations share stimulus, one is monitored at a time.
module tb_seg7_display_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] value;
    logic        waitrequest;
    logic [1:0]  sel;

    always #5 clk = ~clk;

    seg7_display_writer_if #(.ADDR_W(32)) if_def ();
    seg7_display_writer_if #(.ADDR_W(32)) if_blz ();
    seg7_display_writer_if #(.ADDR_W(32)) if_ah  ();
    assign if_def.avm_waitrequest = waitrequest;
    assign if_blz.avm_waitrequest = waitrequest;
    assign if_ah.avm_waitrequest  = waitrequest;

    logic busy_def, done_def, busy_blz, done_blz, busy_ah, done_ah;

    seg7_display_writer dut_def (
        .clk(clk), .reset_n(reset_n), .start(start), .value(value),
        .busy(busy_def), .done(done_def), .avm(if_def));

    seg7_display_writer #(.BLANK_LZ(1'b1)) dut_blz (
        .clk(clk), .reset_n(reset_n), .start(start), .value(value),
        .busy(busy_blz), .done(done_blz), .avm(if_blz));

    seg7_display_writer #(.SEG_ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .reset_n(reset_n), .start(start), .value(value),
        .busy(busy_ah), .done(done_ah), .avm(if_ah));

    logic        mon_write, mon_busy, mon_done;
    logic [31:0] mon_addr, mon_data;

    always_comb begin
        mon_write = if_def.avm_write;
        mon_addr  = if_def.avm_address;
        mon_data  = if_def.avm_writedata;
        mon_busy  = busy_def;
        mon_done  = done_def;
        case (sel)
            2'd1: begin
                mon_write = if_blz.avm_write; mon_addr = if_blz.avm_address;
                mon_data  = if_blz.avm_writedata; mon_busy = busy_blz; mon_done = done_blz;
            end
            2'd2: begin
                mon_write = if_ah.avm_write; mon_addr = if_ah.avm_address;
                mon_data  = if_ah.avm_writedata; mon_busy = busy_ah; mon_done = done_ah;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] val;
        logic [6:0]  seg [4];
    } vec_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerr    = 0;
    int   nwr     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each accepted write is matched against the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && mon_write === 1'b1 && waitrequest === 1'b0) begin
            exp_t e;
            nwr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", mon_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mon_addr, e.addr);
                chk("wr_data", mon_data, e.data);
            end
        end
    end

    task automatic push4(input logic [6:0] s0, s1, s2, s3);
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.addr = 32'(i * 16);
            e.data = {25'b0, s[i]};
            exp_q.push_back(e);
        end
    endtask

    // Leaves the bench one step into cycle 1 (first write cycle).
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (mon_done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", {31'b0, mon_done}, 32'd1);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'd0, 16'h1234, '{7'h19, 7'h30, 7'h24, 7'h79}};
        vecs[1] = '{2'd1, 16'h0005, '{7'h12, 7'h7F, 7'h7F, 7'h7F}};
        vecs[2] = '{2'd1, 16'h0000, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
        vecs[3] = '{2'd2, 16'hABCD, '{7'h5E, 7'h39, 7'h7C, 7'h77}};
        vecs[4] = '{2'd0, 16'h0000, '{7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{2'd1, 16'h0100, '{7'h40, 7'h40, 7'h79, 7'h7F}};
        vecs[6] = '{2'd2, 16'h0000, '{7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[7] = '{2'd0, 16'h8F9E, '{7'h06, 7'h10, 7'h0E, 7'h00}};

        reset_n = 1'b0; start = 1'b0; value = '0; waitrequest = 1'b0; sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {31'b0, mon_busy},  32'd0);
        chk("rst_done",  {31'b0, mon_done},  32'd0);
        chk("rst_write", {31'b0, mon_write}, 32'd0);
        chk("rst_addr",  mon_addr, 32'h0);
        chk("rst_data",  mon_data, 32'h0);
        reset_n = 1'b1;

        // Latency with no stalls: writes cycles 1..4, done cycle 5.
        value = 16'h1234;
        push4(7'h19, 7'h30, 7'h24, 7'h79);
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("lat_write_c%0d", c), {31'b0, mon_write}, {31'b0, (c <= 4)});
            chk($sformatf("lat_busy_c%0d", c),  {31'b0, mon_busy},  {31'b0, (c <= 5)});
            chk($sformatf("lat_done_c%0d", c),  {31'b0, mon_done},  {31'b0, (c == 5)});
            @(posedge clk); #1;
        end
        chk("lat_q_empty", exp_q.size(), 0);

        // Three stall cycles on the second write.
        push4(7'h19, 7'h30, 7'h24, 7'h79);
        pulse_start();
        for (int c = 1; c <= 9; c++) begin
            waitrequest = (c >= 2 && c <= 4);
            if (c >= 2 && c <= 5) begin
                chk($sformatf("stall_addr_c%0d", c), mon_addr, 32'h10);
                chk($sformatf("stall_data_c%0d", c), mon_data, 32'h30);
            end
            chk($sformatf("stall_done_c%0d", c), {31'b0, mon_done}, {31'b0, (c == 8)});
            @(posedge clk); #1;
        end
        waitrequest = 1'b0;
        chk("stall_q_empty", exp_q.size(), 0);

        // Start during WRITE ignored (value change too); start right after done accepted.
        begin
            int base_wr;
            base_wr = nwr;
            push4(7'h19, 7'h30, 7'h24, 7'h79);
            pulse_start();
            @(posedge clk); #1;
            start = 1'b1; value = 16'hFFFF;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done();
            @(posedge clk); #1;
            chk("idle_after_done", {31'b0, mon_busy}, 32'd0);
            value = 16'h00A1;
            push4(7'h79, 7'h08, 7'h40, 7'h40);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("restart_write", {31'b0, mon_write}, 32'd1);
            chk("restart_addr",  mon_addr, 32'h0);
            wait_done();
            @(posedge clk); #1;
            chk("dbl_wr_count", nwr - base_wr, 8);
            chk("dbl_q_empty",  exp_q.size(), 0);
        end

        // Reset during the third write: only two writes complete, no done.
        value = 16'h1234;
        push4(7'h19, 7'h30, 7'h24, 7'h79);
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_addr", mon_addr, 32'h20);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_write", {31'b0, mon_write}, 32'd0);
        chk("mid_rst_busy",  {31'b0, mon_busy},  32'd0);
        chk("mid_rst_addr",  mon_addr, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_no_done", {31'b0, mon_done}, 32'd0);
        end
        chk("rst_q_left", exp_q.size(), 2);
        exp_q.delete();
        reset_n = 1'b1;

        // Table of value/config vectors, each a full 4-write sequence.
        for (int v = 0; v < 8; v++) begin
            sel   = vecs[v].sel;
            value = vecs[v].val;
            push4(vecs[v].seg[0], vecs[v].seg[1], vecs[v].seg[2], vecs[v].seg[3]);
            pulse_start();
            wait_done();
            @(posedge clk); #1;
            chk($sformatf("vec%0d_q_empty", v), exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/seg7_display_writer.md
Name: seg7_display_writer

Overview:
- Avalon-MM master (initiator) that drives the seven-segment display PIO slaves on the NOC interconnect.
- On a start pulse it latches a hex value and encodes each nibble to a 7-segment code.
- It then issues one Avalon write per digit to the data register (word 0) of each display PIO, in order.
- Frees the processor from per-digit PIO writes; sits between a status/result source and the display PIO slaves.

Parameters:
- NUM_DIGITS, 4, number of display PIOs/digits driven; 1..8.
- ADDR_W, 32, Avalon master address width.
- BASE_ADDR, 32'h0000_0000, byte address of display0 PIO.
- STRIDE, 16, byte address step between consecutive display PIOs (each PIO spans 4 words).
- SEG_ACTIVE_LOW, 1, 1: emitted code is inverted (segment lit = 0).
- BLANK_LZ, 0, 1: leading zero digits (above digit 0) are blanked.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to display value; ignored while busy.
- value  in  4*NUM_DIGITS  hex value; nibble i goes to digit i.
- busy  out  1  high from the cycle after an accepted start until done completes.
- done  out  1  one-cycle pulse after the last write is accepted.
- avm_address  out  ADDR_W  byte address of the current write.
- avm_write  out  1  write request.
- avm_writedata  out  32  {25'b0, seg[6:0]}.
- avm_waitrequest  in  1  slave stall; the write is accepted when avm_write && !avm_waitrequest.

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: state IDLE, idx 0, latched value 0, busy 0, done 0, avm_write 0, avm_address BASE_ADDR, avm_writedata 0.
- Reset asserted mid-transfer drops avm_write immediately (async). The partial update is abandoned with no done pulse.
- FSM states: IDLE, WRITE, DONE.
  - IDLE: when start=1, latch value, clear idx, go to WRITE. busy=0.
  - WRITE: avm_write=1, avm_address=BASE_ADDR+idx*STRIDE, avm_writedata=seg(idx).
    - Address, data and write stay stable while avm_waitrequest=1.
    - On acceptance: if idx==NUM_DIGITS-1, go to DONE; else idx+1 and stay in WRITE. Writes are back-to-back with no idle cycle.
  - DONE: done=1 for exactly one cycle, avm_write=0, then IDLE.
- busy = (state != IDLE).
- start is ignored in WRITE and DONE; there is no queueing. A start in the first IDLE cycle after DONE is accepted.
- value changes after the latch have no effect on the transfer in progress.
- Latency with waitrequest tied 0:
  - start sampled at cycle 0.
  - Writes occur in cycles 1..NUM_DIGITS.
  - done occurs in cycle NUM_DIGITS+1.
  - Each waitrequest cycle adds one cycle.
- Encoding: bit0=a, bit1=b, …, bit6=g. Active-high table:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- SEG_ACTIVE_LOW=1 inverts all 7 bits. Blank digit = all segments off (0x7F active-low, 0x00 active-high).
- Blanking with BLANK_LZ=1: digit i>0 is blanked when nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- Address arithmetic is modulo 2^ADDR_W. Writedata bits [31:7] are always 0.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_BLANK_HI/LO constants;
  - the state enum type.
- One sub-module, hex_to_seg7: a purely combinational nibble-to-segment encoder with polarity and blank inputs, instantiated once on the muxed nibble.

Test Plan:
- Defaults, waitrequest=0, value=16'h1234, start pulse -> writes in consecutive cycles 1..4: (0x00,0x19), (0x10,0x30), (0x20,0x24), (0x30,0x79). done pulses in cycle 5; busy is high in cycles 1..5.
- Same stimulus with waitrequest=1 for 3 cycles on the second write -> address 0x10 and data 0x30 are held stable for 4 cycles, no write is skipped or duplicated, done arrives in cycle 8.
- BLANK_LZ=1, value=16'h0005 -> data 0x12, 0x7F, 0x7F, 0x7F. Then value=16'h0000 -> digit 0 = 0x40, others 0x7F.
- SEG_ACTIVE_LOW=0, value=16'hABCD -> data 0x5E, 0x39, 0x7C, 0x77.
- Second start asserted during WRITE -> ignored, exactly 4 writes. start in the first IDLE cycle after done -> new sequence begins.
- reset_n dropped during the 3rd write -> avm_write falls asynchronously, busy=0, no done pulse. After release, a start produces a full 4-write sequence from address BASE_ADDR.
